eu_iqueue_mi: RTL and testbench
===============================

// Module: eu_iqueue_mi
// PURPOSE
//  Per-exec-unit instruction queue, multi-issue generation. Filters the parallel dispatch bus for this EU.
//  Compacts relevant lanes in lane order and stores them in a banked circular FIFO (entry i -> bank i mod NUM_BANKS).
//  Presents up to ISSUE_WIDTH oldest entries per cycle to the EU. Adds all-or-nothing dispatch handshake, flush, occupancy/credit status.
// PARAMETERS
//  NUM_DISPATCH     4    dispatch bus lanes; must be <= NUM_BANKS
//  LOG2_NUM_BANKS   2    log2 bank count (one write port per bank per cycle)
//  LOG2_BANK_DEPTH  4    log2 entries per bank; capacity CAP = 2**(LOG2_NUM_BANKS+LOG2_BANK_DEPTH)
//  ISSUE_WIDTH      2    issue ports; must be <= NUM_BANKS
//  EU_IDX           0    [LOG2_NUM_EXEC_UNITS-1:0] index of owning EU
// PORTS
//  clk                  in   1                       clock, all state on rising edge
//  reset_n              in   1                       asynchronous active-low reset
//  flush_i              in   1                       synchronous queue flush
//  disp_instr_i         in   type_iqueue_entry x NUM_DISPATCH   dispatch payloads
//  disp_valid_i         in   1 x NUM_DISPATCH        lane valid
//  disp_euidx_i         in   LOG2_NUM_EXEC_UNITS x NUM_DISPATCH target EU per lane
//  disp_ready_o         out  1                       whole batch accepted this cycle
//  issue_instr_o        out  type_iqueue_entry x ISSUE_WIDTH    head+j entry
//  issue_valid_o        out  1 x ISSUE_WIDTH         head+j exists
//  issue_ready_i        in   1 x ISSUE_WIDTH         EU takes head+j
//  count_o              out  LOG2_NUM_BANKS+LOG2_BANK_DEPTH+1   occupied entries
//  free_o               out  same width as count_o   CAP - count
//  empty_o / full_o     out  1 each                  count==0 / count==CAP
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr (LOG2_NUM_BANKS+LOG2_BANK_DEPTH bits, natural wrap), count, bank storage. No other state.
//  - Reset: ptrs=0, count=0 -> issue_valid_o=0, empty_o=1, full_o=0, free_o=CAP. Storage contents don't care.
//  - Reset mid-operation discards all entries immediately (async).
//  - Relevant lane: disp_valid_i[l] & disp_euidx_i[l]==EU_IDX. k = popcount(relevant), 0..NUM_DISPATCH.
//  - Rank r = number of relevant lanes below l. Rank r is written at logical index wr_ptr+r.
//  - Lane gaps never create holes.
//  - disp_ready_o = (k <= free_o) & ~flush_i. Combinational from dispatch inputs and current count only.
//  - Slots freed by same-cycle issue are NOT counted. k==0 -> ready=1 unless flushing.
//  - Accept is all-or-nothing. On ready=0 nothing is written; front end holds the batch unchanged.
//  - Accepted: wr_ptr += k.
//  - Issue: issue_valid_o[j] = (count > j) & ~flush_i. issue_instr_o[j] = entry at rd_ptr+j, combinational read of storage.
//  - Issue ports are in-order: pops p = length of the leading run of j with issue_valid_o[j] & issue_ready_i[j].
//  - issue_ready_i[j] is ignored once a lower port fails. rd_ptr += p.
//  - count_next = count + k_acc - p. Simultaneous dispatch and issue on a full or empty queue is legal.
//  - No same-cycle bypass: latency from dispatch edge to issue_valid is 1 cycle.
//  - Flush: next edge sets ptrs=0, count=0. Dispatch and issue in the flush cycle are dropped and have no effect.
//  - Flush has priority over all other events.
//  - Occupancy is a single logical FIFO, so one global count is sufficient; no per-bank full logic.
//  - Invariant: count <= CAP always. Assertion: p <= count; k_acc <= free.
// STRUCTURE
//  - pkg_dtypes: type_iqueue_entry and LOG2_NUM_EXEC_UNITS (existing).
//  - pkg_dtypes: add localparam-derived type_iq_ptr width helper.
//  - Sub-module eu_iq_lane_compactor (combinational): relevance filter, prefix-count ranks, k.
//    Output is NUM_BANKS write slots rotated by wr_ptr[LOG2_NUM_BANKS-1:0].
//  - Banks: generate NUM_BANKS register arrays of depth 2**LOG2_BANK_DEPTH.
//    Address = ptr[MSBs:LOG2_NUM_BANKS], bank = ptr[LOG2_NUM_BANKS-1:0].
//  - Top: pointer/count regs, handshake, issue read mux.
// TESTING
//  1 Reset then idle -> issue_valid=00, empty=1, free=64, disp_ready=1 with no valid lanes.
//  2 Lanes {valid,eu}={1,0},{1,1},{0,0},{1,0}, EU_IDX=0 -> lanes 0,3 accepted.
//    Next cycle issue_instr[0]=lane0, issue_instr[1]=lane3, count=2.
//  3 Fill to count=62, offer k=3 -> disp_ready=0, count holds.
//    Same-cycle issue_ready=11 -> count=60, ready still 0 that cycle. Retry next cycle -> ready=1, count=63.
//  4 count=5, issue_ready=10 -> p=1. issue_ready=01 -> p=0, rd_ptr unchanged.
//  5 Run 200 random batches across wrap of both ptrs with scoreboard -> exact in-order issue, no loss or duplication.
//  6 count=7 with k=2 dispatch and issue_ready=11 asserted together with flush_i -> next cycle count=0, ptrs=0, empty=1.
//    Assert reset_n low mid-burst -> outputs at reset values before next edge.

Source files
------------

// File: rtl/eu_iqueue_mi_pkg.sv
// Shared datatypes for the per-EU multi-issue instruction queue.
package eu_iqueue_mi_pkg;

  localparam int LOG2_NUM_EXEC_UNITS = 2;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  dst;
    logic [15:0] payload;
  } type_iqueue_entry;

  // Logical queue index width; natural wrap of this width spans the whole capacity.
  function automatic int iq_ptr_width(input int log2_num_banks, input int log2_bank_depth);
    return log2_num_banks + log2_bank_depth;
  endfunction

endpackage

// File: rtl/eu_iqueue_mi_if.sv
// Dispatch and issue handshake bundle; the queue is the slave side.
interface eu_iqueue_mi_if
  import eu_iqueue_mi_pkg::*;
#(
  parameter int NUM_DISPATCH = 4,
  parameter int ISSUE_WIDTH  = 2
);

  type_iqueue_entry [NUM_DISPATCH-1:0]                          disp_instr_i;
  logic             [NUM_DISPATCH-1:0]                          disp_valid_i;
  logic             [NUM_DISPATCH-1:0][LOG2_NUM_EXEC_UNITS-1:0] disp_euidx_i;
  logic                                                         disp_ready_o;
  type_iqueue_entry [ISSUE_WIDTH-1:0]                           issue_instr_o;
  logic             [ISSUE_WIDTH-1:0]                           issue_valid_o;
  logic             [ISSUE_WIDTH-1:0]                           issue_ready_i;

  modport master (
    output disp_instr_i, disp_valid_i, disp_euidx_i, issue_ready_i,
    input  disp_ready_o, issue_instr_o, issue_valid_o
  );

  modport slave (
    input  disp_instr_i, disp_valid_i, disp_euidx_i, issue_ready_i,
    output disp_ready_o, issue_instr_o, issue_valid_o
  );

endinterface

// File: rtl/eu_iq_lane_compactor.sv
// Selects dispatch lanes aimed at this EU and packs them, in lane order,
// into bank write slots starting at the bank of the current write pointer.
module eu_iq_lane_compactor
  import eu_iqueue_mi_pkg::*;
#(
  parameter int NUM_DISPATCH   = 4,
  parameter int LOG2_NUM_BANKS = 2,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX = '0,
  localparam int NB = 2 ** LOG2_NUM_BANKS,
  localparam int KW = $clog2(NUM_DISPATCH + 1)
) (
  input  type_iqueue_entry [NUM_DISPATCH-1:0]                          disp_instr,
  input  logic             [NUM_DISPATCH-1:0]                          disp_valid,
  input  logic             [NUM_DISPATCH-1:0][LOG2_NUM_EXEC_UNITS-1:0] disp_euidx,
  input  logic             [LOG2_NUM_BANKS-1:0]                        wr_bank,
  output logic             [NB-1:0]                                    slot_we,
  output type_iqueue_entry [NB-1:0]                                    slot_data,
  output logic             [KW-1:0]                                    k
);

  logic [KW-1:0]             rank_s;
  logic [LOG2_NUM_BANKS-1:0] bank_s;

  // Prefix-count ranks; NUM_DISPATCH <= NB guarantees one lane per bank at most.
  always_comb begin
    slot_we   = '0;
    slot_data = '0;
    rank_s    = '0;
    bank_s    = '0;
    for (int l = 0; l < NUM_DISPATCH; l++) begin
      if (disp_valid[l] && (disp_euidx[l] == EU_IDX)) begin
        bank_s            = wr_bank + LOG2_NUM_BANKS'(rank_s);
        slot_we[bank_s]   = 1'b1;
        slot_data[bank_s] = disp_instr[l];
        rank_s            = rank_s + KW'(1);
      end else begin
        rank_s = rank_s;
      end
    end
    k = rank_s;
  end

endmodule

// File: rtl/eu_iqueue_mi_chk.sv
// Occupancy invariants of the instruction queue.
module eu_iqueue_mi_chk #(
  parameter int CW  = 7,
  parameter int KW  = 3,
  parameter int PCW = 2
) (
  input logic           clk,
  input logic           reset_n,
  input logic [PCW-1:0] pops,
  input logic [KW-1:0]  k_acc,
  input logic [CW-1:0]  count,
  input logic [CW-1:0]  free
);

  a_pops_le_count : assert property (@(posedge clk) disable iff (!reset_n) CW'(pops) <= count);
  a_kacc_le_free  : assert property (@(posedge clk) disable iff (!reset_n) CW'(k_acc) <= free);
  a_count_le_cap  : assert property (@(posedge clk) disable iff (!reset_n) (count + free) == (count_cap()));

  function automatic logic [CW-1:0] count_cap();
    return CW'(1) << (CW - 1);
  endfunction

endmodule

// File: rtl/eu_iqueue_mi.sv
// Per-EU instruction queue: banked circular FIFO filled from the dispatch
// bus and drained in order through up to ISSUE_WIDTH issue ports.
module eu_iqueue_mi
  import eu_iqueue_mi_pkg::*;
#(
  parameter int NUM_DISPATCH    = 4,
  parameter int LOG2_NUM_BANKS  = 2,
  parameter int LOG2_BANK_DEPTH = 4,
  parameter int ISSUE_WIDTH     = 2,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX = '0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   flush_i,
  eu_iqueue_mi_if.slave                          iq,
  output logic [LOG2_NUM_BANKS+LOG2_BANK_DEPTH:0] count_o,
  output logic [LOG2_NUM_BANKS+LOG2_BANK_DEPTH:0] free_o,
  output logic                                   empty_o,
  output logic                                   full_o
);

  localparam int NB  = 2 ** LOG2_NUM_BANKS;
  localparam int BD  = 2 ** LOG2_BANK_DEPTH;
  localparam int PW  = iq_ptr_width(LOG2_NUM_BANKS, LOG2_BANK_DEPTH);
  localparam int CW  = PW + 1;
  localparam int KW  = $clog2(NUM_DISPATCH + 1);
  localparam int PCW = $clog2(ISSUE_WIDTH + 1);
  localparam logic [CW-1:0] CAP = CW'(2 ** PW);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] free_r;
  logic          empty_r;
  logic          full_r;

  logic             [NB-1:0]                   slot_we_s;
  type_iqueue_entry [NB-1:0]                   slot_data_s;
  logic             [KW-1:0]                   k_s;
  logic             [KW-1:0]                   k_acc_s;
  logic                                        accept_s;
  logic             [PCW-1:0]                  pops_s;
  logic                                        run_s;
  logic             [CW-1:0]                   count_next_s;
  logic             [ISSUE_WIDTH-1:0][PW-1:0]  rd_idx_s;
  type_iqueue_entry [NB-1:0][ISSUE_WIDTH-1:0]  bank_rd_s;

  eu_iq_lane_compactor #(
    .NUM_DISPATCH  (NUM_DISPATCH),
    .LOG2_NUM_BANKS(LOG2_NUM_BANKS),
    .EU_IDX        (EU_IDX)
  ) u_compactor (
    .disp_instr(iq.disp_instr_i),
    .disp_valid(iq.disp_valid_i),
    .disp_euidx(iq.disp_euidx_i),
    .wr_bank   (wr_ptr_r[LOG2_NUM_BANKS-1:0]),
    .slot_we   (slot_we_s),
    .slot_data (slot_data_s),
    .k         (k_s)
  );

  // Ready looks only at the registered free count, never at same-cycle pops.
  assign iq.disp_ready_o = (CW'(k_s) <= free_r) & ~flush_i;
  assign accept_s        = iq.disp_ready_o;
  assign k_acc_s         = accept_s ? k_s : '0;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    type_iqueue_entry          mem_r [BD];
    logic [LOG2_NUM_BANKS-1:0] offs_s;
    logic [PW-1:0]             wr_idx_s;

    assign offs_s   = LOG2_NUM_BANKS'(b) - wr_ptr_r[LOG2_NUM_BANKS-1:0];
    assign wr_idx_s = wr_ptr_r + PW'(offs_s);

    // Bank storage write; contents need no reset since validity lives in count.
    always_ff @(posedge clk) begin
      if (accept_s && slot_we_s[b]) begin
        mem_r[wr_idx_s[PW-1:LOG2_NUM_BANKS]] <= slot_data_s[b];
      end
    end

    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_rd
      assign bank_rd_s[b][j] = mem_r[rd_idx_s[j][PW-1:LOG2_NUM_BANKS]];
    end
  end

  for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_port
    assign rd_idx_s[j]         = rd_ptr_r + PW'(j);
    assign iq.issue_instr_o[j] = bank_rd_s[rd_idx_s[j][LOG2_NUM_BANKS-1:0]][j];
    assign iq.issue_valid_o[j] = (count_r > CW'(j)) & ~flush_i;
  end

  // Pops are the leading run of accepted ports; a refused port blocks all above it.
  always_comb begin
    pops_s = '0;
    run_s  = 1'b1;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (run_s && iq.issue_valid_o[j] && iq.issue_ready_i[j]) begin
        pops_s = pops_s + PCW'(1);
      end else begin
        run_s = 1'b0;
      end
    end
    count_next_s = count_r + CW'(k_acc_s) - CW'(pops_s);
  end

  // Pointer and occupancy registers; flush outranks dispatch and issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      free_r   <= CAP;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      free_r   <= CAP;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PW'(k_acc_s);
      rd_ptr_r <= rd_ptr_r + PW'(pops_s);
      count_r  <= count_next_s;
      free_r   <= CAP - count_next_s;
      empty_r  <= (count_next_s == '0);
      full_r   <= (count_next_s == CAP);
    end
  end

  assign count_o = count_r;
  assign free_o  = free_r;
  assign empty_o = empty_r;
  assign full_o  = full_r;

  eu_iqueue_mi_chk #(
    .CW (CW),
    .KW (KW),
    .PCW(PCW)
  ) u_chk (
    .clk    (clk),
    .reset_n(reset_n),
    .pops   (pops_s),
    .k_acc  (k_acc_s),
    .count  (count_r),
    .free   (free_r)
  );

endmodule

// File: tb/tb_eu_iqueue_mi.sv
// Randomized bench for eu_iqueue_mi against a queue-based reference model.
module tb_eu_iqueue_mi;
  import eu_iqueue_mi_pkg::*;

  localparam int ND  = 4;
  localparam int IW  = 2;
  localparam int CAP = 64;
  localparam logic [LOG2_NUM_EXEC_UNITS-1:0] EU = '0;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush_i = 1'b0;
  logic [6:0] count_o;
  logic [6:0] free_o;
  logic       empty_o;
  logic       full_o;

  eu_iqueue_mi_if #(.NUM_DISPATCH(ND), .ISSUE_WIDTH(IW)) bus ();

  eu_iqueue_mi #(
    .NUM_DISPATCH   (ND),
    .LOG2_NUM_BANKS (2),
    .LOG2_BANK_DEPTH(4),
    .ISSUE_WIDTH    (IW),
    .EU_IDX         (EU)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush_i(flush_i),
    .iq     (bus),
    .count_o(count_o),
    .free_o (free_o),
    .empty_o(empty_o),
    .full_o (full_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  type_iqueue_entry model_q[$];
  logic [31:0] d_a, d_b, d_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    bus.disp_valid_i  = '0;
    bus.disp_euidx_i  = '0;
    bus.disp_instr_i  = '0;
    bus.issue_ready_i = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [1:0] eu, input logic [31:0] d);
    bus.disp_valid_i[l] = v;
    bus.disp_euidx_i[l] = eu;
    bus.disp_instr_i[l] = d;
  endtask

  task automatic rand_batch();
    for (int l = 0; l < ND; l++) begin
      set_lane(l, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
               $urandom);
    end
    bus.issue_ready_i = 2'($urandom);
  endtask

  // One clock: check combinational outputs, advance the model, check status.
  task automatic cycle();
    int k;
    int p;
    bit rdy;
    bit stop;
    bit exp_v;
    type_iqueue_entry acc[$];
    #1;
    k = 0;
    for (int l = 0; l < ND; l++) begin
      if (bus.disp_valid_i[l] && bus.disp_euidx_i[l] == EU) begin
        k++;
        acc.push_back(bus.disp_instr_i[l]);
      end
    end
    rdy = (k <= CAP - model_q.size()) && !flush_i;
    check("disp_ready", 32'(bus.disp_ready_o), 32'(rdy));
    p = 0;
    stop = 1'b0;
    for (int j = 0; j < IW; j++) begin
      exp_v = (model_q.size() > j) && !flush_i;
      check($sformatf("issue_valid%0d", j), 32'(bus.issue_valid_o[j]), 32'(exp_v));
      if (exp_v) check($sformatf("issue_instr%0d", j), bus.issue_instr_o[j], model_q[j]);
      if (!stop && exp_v && bus.issue_ready_i[j]) p++;
      else stop = 1'b1;
    end
    @(posedge clk);
    if (flush_i) begin
      model_q.delete();
    end else begin
      repeat (p) void'(model_q.pop_front());
      if (rdy) foreach (acc[i]) model_q.push_back(acc[i]);
    end
    #1;
    check("count", 32'(count_o), 32'(model_q.size()));
    check("free", 32'(free_o), 32'(CAP - model_q.size()));
    check("empty", 32'(empty_o), 32'(model_q.size() == 0));
    check("full", 32'(full_o), 32'(model_q.size() == CAP));
    @(negedge clk);
  endtask

  task automatic fill4();
    for (int l = 0; l < ND; l++) set_lane(l, 1'b1, 2'd0, $urandom);
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    #1;
    check("t1_valid", 32'(bus.issue_valid_o), 32'd0);
    check("t1_empty", 32'(empty_o), 32'd1);
    check("t1_free", 32'(free_o), 32'd64);
    check("t1_ready", 32'(bus.disp_ready_o), 32'd1);
    cycle();

    // lane compaction: lanes 0 and 3 belong to this EU
    d_a = 32'hA0A0_0001; d_b = 32'hB0B0_0002; d_c = 32'hC0C0_0003;
    set_lane(0, 1'b1, 2'd0, d_a);
    set_lane(1, 1'b1, 2'd1, d_b);
    set_lane(2, 1'b0, 2'd0, 32'h1111_1111);
    set_lane(3, 1'b1, 2'd0, d_c);
    cycle();
    idle();
    #1;
    check("t2_instr0", bus.issue_instr_o[0], d_a);
    check("t2_instr1", bus.issue_instr_o[1], d_c);
    check("t2_count", 32'(count_o), 32'd2);
    cycle();

    // near-full: no credit for same-cycle pops
    flush_i = 1'b1; cycle(); flush_i = 1'b0;
    for (int i = 0; i < 15; i++) begin fill4(); cycle(); end
    idle(); set_lane(0, 1'b1, 2'd0, $urandom); set_lane(1, 1'b1, 2'd0, $urandom); cycle();
    check("t3_count62", 32'(count_o), 32'd62);
    idle(); for (int l = 0; l < 3; l++) set_lane(l, 1'b1, 2'd0, $urandom);
    #1; check("t3_ready_hold", 32'(bus.disp_ready_o), 32'd0);
    cycle();
    check("t3_count_hold", 32'(count_o), 32'd62);
    bus.issue_ready_i = 2'b11;
    #1; check("t3_ready_pop", 32'(bus.disp_ready_o), 32'd0);
    cycle();
    check("t3_count60", 32'(count_o), 32'd60);
    bus.issue_ready_i = 2'b00;
    #1; check("t3_ready_retry", 32'(bus.disp_ready_o), 32'd1);
    cycle();
    check("t3_count63", 32'(count_o), 32'd63);

    // in-order issue ports
    idle(); flush_i = 1'b1; cycle(); flush_i = 1'b0;
    fill4(); cycle();
    idle(); set_lane(2, 1'b1, 2'd0, $urandom); cycle();
    idle(); bus.issue_ready_i[0] = 1'b1; cycle();
    check("t4_p1", 32'(count_o), 32'd4);
    idle(); bus.issue_ready_i[1] = 1'b1; cycle();
    check("t4_p0", 32'(count_o), 32'd4);

    // random traffic across pointer wrap
    for (int i = 0; i < 200; i++) begin
      rand_batch();
      flush_i = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush_i = 1'b0;

    // flush priority over dispatch and issue
    idle(); flush_i = 1'b1; cycle(); flush_i = 1'b0;
    fill4(); cycle();
    idle(); for (int l = 0; l < 3; l++) set_lane(l, 1'b1, 2'd0, $urandom); cycle();
    check("t6_count7", 32'(count_o), 32'd7);
    idle(); set_lane(0, 1'b1, 2'd0, $urandom); set_lane(3, 1'b1, 2'd0, $urandom);
    bus.issue_ready_i = 2'b11; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check("t6_count0", 32'(count_o), 32'd0);
    check("t6_empty", 32'(empty_o), 32'd1);
    idle(); set_lane(1, 1'b1, 2'd0, 32'h5A5A_0F0F); cycle();
    idle(); #1; check("t6_after_flush", bus.issue_instr_o[0], 32'h5A5A_0F0F);
    cycle();

    // asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) begin fill4(); cycle(); end
    rand_batch();
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.issue_valid_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_free", 32'(free_o), 32'd64);
    check("rst_full", 32'(full_o), 32'd0);
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_batch(); cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
